// File: rtl/trans_seq_pkg.sv
// Shared types and default sizing for the round-robin transaction sequencer.
// Holds the phase-state encoding used by the top-level FSM.
package trans_seq_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StTrans,
      StStart,
      StPhA,
      StPhB,
      StPhC,
      StEnd
   } state_e;

   localparam int unsigned NReqDefault = 4;
   localparam int unsigned CntWDefault = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches from last_winner+1 with wrap-around, skipping masked requesters.
// Purely combinational; the caller registers the grant and the winner index.
module rr_arbiter #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned IDX_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [N_REQ-1:0] mask,
   input  logic [IDX_W-1:0] last_winner,
   output logic [N_REQ-1:0] winner,
   output logic             valid
);

   logic [N_REQ-1:0] cand;
   logic [IDX_W-1:0] idx;

   always_comb begin
      cand   = req & ~mask;
      winner = '0;
      valid  = 1'b0;
      idx    = '0;
      // i == N_REQ lands back on last_winner, so it has the lowest priority.
      for (int unsigned i = 1; i <= N_REQ; i++) begin
         idx = IDX_W'((32'(last_winner) + i) % N_REQ);
         if (!valid && cand[idx]) begin
            winner[idx] = 1'b1;
            valid       = 1'b1;
         end
      end
   end

endmodule

// File: rtl/trans_seq_arb.sv
// Arbitrates N_REQ requesters onto one target and walks each grant through the fixed
// TRANS, START, A, B, C, END phase sequence, counting completed transactions.
module trans_seq_arb
   import trans_seq_pkg::*;
#(
   parameter int unsigned N_REQ = NReqDefault,
   parameter int unsigned CNT_W = CntWDefault
) (
   input  logic             sysclk,
   input  logic             rst,
   input  logic [N_REQ-1:0] req,
   input  logic             busy,
   output logic [N_REQ-1:0] gnt,
   output logic [N_REQ-1:0] ack,
   output logic             trans,
   output logic             start_trans,
   output logic             a,
   output logic             b,
   output logic             c,
   output logic             end_trans,
   output logic [CNT_W-1:0] txn_cnt
);

   localparam int unsigned IdxW = $clog2(N_REQ);

   state_e           state_q, state_d;
   logic [N_REQ-1:0] gnt_q, gnt_d;
   logic [IdxW-1:0]  last_q, last_d;
   logic [CNT_W-1:0] cnt_q;
   logic [N_REQ-1:0] arb_mask, arb_winner;
   logic [IdxW-1:0]  winner_idx;
   logic             arb_valid;
   logic             launch;

   // Mask the finishing winner only when someone else is waiting, so a sole requester re-wins.
   always_comb begin
      arb_mask = '0;
      if (state_q == StEnd && |(req & ~gnt_q)) begin
         arb_mask = gnt_q;
      end
   end

   rr_arbiter #(
      .N_REQ(N_REQ),
      .IDX_W(IdxW)
   ) u_rr_arbiter (
      .req        (req),
      .mask       (arb_mask),
      .last_winner(last_q),
      .winner     (arb_winner),
      .valid      (arb_valid)
   );

   always_comb begin
      winner_idx = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (arb_winner[i]) winner_idx = IdxW'(i);
      end
   end

   assign launch = arb_valid && !busy;

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      last_d  = last_q;
      unique case (state_q)
         StIdle, StEnd: begin
            if (launch) begin
               state_d = StTrans;
               gnt_d   = arb_winner;
               last_d  = winner_idx;
            end else begin
               state_d = StIdle;
               gnt_d   = '0;
            end
         end
         StTrans: state_d = StStart;
         StStart: state_d = StPhA;
         StPhA:   state_d = StPhB;
         StPhB:   state_d = StPhC;
         StPhC:   state_d = StEnd;
         default: begin
            state_d = StIdle;
            gnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge sysclk) begin
      if (rst) begin
         state_q <= StIdle;
         gnt_q   <= '0;
         last_q  <= IdxW'(N_REQ - 1);
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         last_q  <= last_d;
         if (state_q == StEnd) cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   always_comb begin
      trans       = (state_q == StTrans);
      start_trans = (state_q == StStart);
      a           = (state_q == StPhA);
      b           = (state_q == StPhB);
      c           = (state_q == StPhC);
      end_trans   = (state_q == StEnd);
      gnt         = gnt_q;
      ack         = (state_q == StEnd) ? gnt_q : '0;
      txn_cnt     = cnt_q;
   end

endmodule

// File: doc/trans_seq_arb.md
TRANS_SEQ_ARB -- requirements
Module: trans_seq_arb

Interface
REQ-001 Parameter N_REQ, default 4, SHALL set the number of requesters (legal range 2..8).
REQ-002 Parameter CNT_W, default 16, SHALL set the width of the completed-transaction counter.
REQ-003 sysclk  input  1  SHALL be the single clock; all state updates on posedge sysclk.
REQ-004 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 req  input  N_REQ  SHALL carry per-requester transaction requests (level, held until ack).
REQ-006 busy  input  1  SHALL, when high, block the start of any new transaction (target not ready).
REQ-007 gnt  output  N_REQ  SHALL be the one-hot grant, held for the whole transaction.
REQ-008 ack  output  N_REQ  SHALL be a one-hot, one-cycle completion pulse to the granted requester.
REQ-009 trans, start_trans, a, b, c, end_trans  output  1 each  SHALL be the phase strobes driven to the target.
REQ-010 txn_cnt  output  CNT_W  SHALL count completed transactions.

Function
REQ-011 FSM states SHALL be IDLE, TRANS, START, PH_A, PH_B, PH_C, END.
REQ-012 Each non-IDLE state SHALL last exactly one cycle and assert only its own strobe: TRANS->trans, START->start_trans, PH_A->a, PH_B->b, PH_C->c, END->end_trans.
REQ-013 Transaction order SHALL be fixed: TRANS->START->PH_A->PH_B->PH_C->END, with no stalls, so that trans ##1 start_trans ##1 a ##1 b ##1 c ##1 end_trans holds on every transaction.
REQ-014 In IDLE, when |req and !busy, the FSM SHALL select a winner and enter TRANS on the next cycle; otherwise it SHALL remain in IDLE with all strobes low.
REQ-015 Arbitration SHALL be round-robin: search begins at index (last_winner+1) mod N_REQ and wraps; after reset, last_winner = N_REQ-1, so index 0 has first priority.
REQ-016 gnt SHALL assert in the TRANS cycle and stay constant through END; req changes during a transaction SHALL NOT alter gnt.
REQ-017 ack[winner] SHALL pulse high in the END cycle only.
REQ-018 In END, if |req (excluding the current winner's req) and !busy, the FSM SHALL go directly to TRANS with a new winner (back-to-back, zero idle cycles); otherwise it SHALL go to IDLE.
REQ-019 The current winner's req SHALL be masked in the END-cycle arbitration; that requester may win again only from IDLE or when it is the sole requester.
REQ-020 If the winner is the sole requester in END, it SHALL re-win back-to-back.
REQ-021 busy SHALL be sampled only in IDLE and END; busy during TRANS..PH_C SHALL have no effect.
REQ-022 A req deasserted mid-transaction SHALL NOT abort the transaction; it completes.
REQ-023 txn_cnt SHALL increment by 1 in the cycle after END and wrap modulo 2^CNT_W.
REQ-024 At most one phase strobe SHALL be high in any cycle, and none SHALL be high in IDLE.

Reset
REQ-025 rst high SHALL force, on the next edge: state=IDLE, all strobes=0, gnt=0, ack=0, txn_cnt=0, last_winner=N_REQ-1.
REQ-026 rst asserted mid-transaction SHALL abandon the transaction with no ack and no counter increment.
REQ-027 The first transaction after rst deassertion SHALL start no earlier than one cycle after the first IDLE cycle.

Structure
REQ-028 A shared package trans_seq_pkg SHALL hold the phase-state enum and default parameter constants.
REQ-029 Arbitration SHALL be implemented in a sub-module rr_arbiter (inputs req, mask, last_winner; outputs one-hot winner and valid).

Verification
REQ-030 Single requester: req=4'b0001, busy=0 -> trans..end_trans on 6 consecutive cycles, gnt=0001, one ack, txn_cnt=1.
REQ-031 All requesting: req=4'b1111 held -> winners 0,1,2,3,0 back-to-back, a new trans on the cycle after each end_trans.
REQ-032 Busy gating: req=4'b0100, busy=1 for 5 cycles -> no strobes; busy drops -> trans asserts 1 cycle later.
REQ-033 Mid-transaction reset: rst pulsed during PH_B -> all outputs 0 next cycle, no ack, txn_cnt unchanged at 0.
REQ-034 Counter wrap: CNT_W=2, 5 transactions -> txn_cnt sequence 1,2,3,0,1.
REQ-035 Assertion check: the bound property trans ##1 start_trans ##1 a ##1 b ##1 c ##1 end_trans SHALL pass for every granted transaction, and strobe mutual exclusion SHALL hold throughout.
